// File: rtl/shift_ring_reg.sv
// shift_ring_reg: DEPTH x WIDTH register chain with hold/shift/rotate/load, sync clear, fill tracker.
// Optional parity output enabled by defining SHIFT_RING_PARITY_EN.
module shift_ring_reg #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sclr,
  input  logic [1:0]               mode,
  input  logic                     dir,
  input  logic [WIDTH-1:0]         ser_in,
  input  logic [WIDTH*DEPTH-1:0]   par_in,
  output logic [WIDTH*DEPTH-1:0]   q_all,
  output logic [WIDTH-1:0]         ser_out,
  output logic [FILL_W-1:0]        fill,
  output logic                     full,
  output logic                     par
);
  logic [DEPTH-1:0][WIDTH-1:0] r_stage;
  logic [DEPTH-1:0][WIDTH-1:0] w_next;
  logic [FILL_W-1:0]           r_fill;
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    localparam int LO = (i + DEPTH - 1) % DEPTH;
    localparam int HI = (i + 1) % DEPTH;
    logic [WIDTH-1:0] w_nb;
    logic             w_edge;
    // In shift mode the stage at the entry end takes ser_in instead of the wrapped neighbour
    assign w_nb   = dir ? r_stage[HI] : r_stage[LO];
    assign w_edge = dir ? (i == DEPTH - 1) : (i == 0);
    assign w_next[i] = (mode == 2'b11) ? par_in[i*WIDTH +: WIDTH] :
                       (mode == 2'b10) ? w_nb :
                       (mode == 2'b01) ? (w_edge ? ser_in : w_nb) : r_stage[i];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage <= '0;
      r_fill  <= '0;
    end else if (sclr) begin
      r_stage <= '0;
      r_fill  <= '0;
    end else begin
      r_stage <= w_next;
      if (mode == 2'b11) r_fill <= FILL_W'(DEPTH);
      else if (mode == 2'b01 && !full) r_fill <= r_fill + FILL_W'(1);
    end
  end
  assign q_all   = r_stage;
  assign ser_out = dir ? r_stage[0] : r_stage[DEPTH-1];
  assign fill    = r_fill;
  assign full    = (r_fill == FILL_W'(DEPTH));
`ifdef SHIFT_RING_PARITY_EN
  assign par = ^r_stage;
`else
  assign par = 1'b0;
`endif
endmodule

// File: tb/tb_shift_ring_reg.sv
// tb_shift_ring_reg: scoreboard bench for shift_ring_reg (WIDTH=4, DEPTH=3 and DEPTH=2 instances).
module tb_shift_ring_reg;
  logic        clk = 0, rst = 1;
  logic        sclr = 0, dir = 0;
  logic [1:0]  mode = 0;
  logic [3:0]  ser_in = 0, ser_out;
  logic [11:0] par_in = 0, q_all;
  logic [1:0]  fill;
  logic        full, par;
  logic        sclr2 = 0, dir2 = 0;
  logic [1:0]  mode2 = 0, fill2;
  logic [3:0]  ser2 = 0, so2;
  logic [7:0]  par2_in = 0, q2;
  logic        full2, par2;
  int checks = 0, errors = 0;
  typedef struct { logic [11:0] q; logic [1:0] fill; logic [3:0] so; } exp_t;
  exp_t sb[$];
  logic [7:0] sb2[$];
  logic [3:0] m[3];
  int mfill = 0;

  shift_ring_reg #(.WIDTH(4), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .sclr(sclr), .mode(mode), .dir(dir), .ser_in(ser_in),
    .par_in(par_in), .q_all(q_all), .ser_out(ser_out), .fill(fill), .full(full), .par(par));
  shift_ring_reg #(.WIDTH(4), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .sclr(sclr2), .mode(mode2), .dir(dir2), .ser_in(ser2),
    .par_in(par2_in), .q_all(q2), .ser_out(so2), .fill(fill2), .full(full2), .par(par2));

  always #5 clk = ~clk;

  function automatic logic exp_par(input logic [11:0] q);
`ifdef SHIFT_RING_PARITY_EN
    return ^q;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step(input logic sc, input logic [1:0] md, input logic d,
                      input logic [3:0] s, input logic [11:0] p);
    logic [3:0] n[3];
    exp_t e, g;
    sclr = sc; mode = md; dir = d; ser_in = s; par_in = p;
    n = m;
    if (sc) begin
      n = '{4'h0, 4'h0, 4'h0};
      mfill = 0;
    end else if (md == 2'b01) begin
      if (!d) n = '{s, m[0], m[1]};
      else    n = '{m[1], m[2], s};
      mfill = (mfill < 3) ? mfill + 1 : 3;
    end else if (md == 2'b10) begin
      if (!d) n = '{m[2], m[0], m[1]};
      else    n = '{m[1], m[2], m[0]};
    end else if (md == 2'b11) begin
      n = '{p[3:0], p[7:4], p[11:8]};
      mfill = 3;
    end
    m = n;
    e.q = {m[2], m[1], m[0]};
    e.fill = 2'(mfill);
    e.so = d ? m[0] : m[2];
    sb.push_back(e);
    @(posedge clk); #1;
    g = sb.pop_front();
    checks++; if (q_all !== g.q) begin errors++; $display("FAIL q_all got %h want %h", q_all, g.q); end
    checks++; if (fill !== g.fill) begin errors++; $display("FAIL fill got %0d want %0d", fill, g.fill); end
    checks++; if (full !== (g.fill == 2'd3)) begin errors++; $display("FAIL full got %b want %b", full, g.fill == 2'd3); end
    checks++; if (ser_out !== g.so) begin errors++; $display("FAIL ser_out got %h want %h", ser_out, g.so); end
    checks++; if (par !== exp_par(g.q)) begin errors++; $display("FAIL par got %b want %b", par, exp_par(g.q)); end
    sclr = 0;
  endtask

  task automatic test_reset;
    checks++; if (q_all !== 0 || fill !== 0 || full !== 0 || ser_out !== 0 || par !== 0) begin
      errors++; $display("FAIL reset_state got q=%h f=%0d full=%b want 0", q_all, fill, full); end
    @(posedge clk); #1 rst = 0;
    m = '{4'h0, 4'h0, 4'h0}; mfill = 0;
    step(0, 2'b01, 0, 4'h9, 0);
    step(0, 2'b01, 0, 4'h8, 0);
    #2 rst = 1;
    #1;
    checks++; if (q_all !== 0 || fill !== 0 || full !== 0) begin
      errors++; $display("FAIL async_reset got q=%h f=%0d full=%b want 0", q_all, fill, full); end
    m = '{4'h0, 4'h0, 4'h0}; mfill = 0;
    #1 rst = 0;
    step(0, 2'b11, 0, 0, 12'h321);
    step(1, 2'b11, 0, 0, 12'hfff);
    checks++; if (q_all !== 0 || fill !== 0) begin
      errors++; $display("FAIL sclr_over_load got q=%h f=%0d want 0", q_all, fill); end
  endtask

  task automatic test_shift_up;
    for (int i = 1; i <= 4; i++) begin
      step(0, 2'b01, 0, 4'(i), 0);
      checks++; if (full !== (i >= 3)) begin errors++; $display("FAIL full_edge%0d got %b want %b", i, full, i >= 3); end
    end
    checks++; if (q_all !== 12'h234) begin errors++; $display("FAIL shift_up got %h want 234", q_all); end
  endtask

  task automatic test_shift_down;
    step(0, 2'b11, 1, 0, 12'habc);
    checks++; if (ser_out !== 4'hc) begin errors++; $display("FAIL ser_out_load got %h want c", ser_out); end
    step(0, 2'b01, 1, 4'h5, 0);
    checks++; if (q_all !== 12'h5ab || ser_out !== 4'hb) begin
      errors++; $display("FAIL shift_down got %h/%h want 5ab/b", q_all, ser_out); end
  endtask

  task automatic test_rotate;
    step(0, 2'b11, 0, 0, 12'h321);
    for (int i = 0; i < 3; i++) step(0, 2'b10, 0, 4'hf, 0);
    checks++; if (q_all !== 12'h321) begin errors++; $display("FAIL rotate_x3 got %h want 321", q_all); end
    step(0, 2'b10, 1, 4'hf, 0);
    checks++; if (q_all !== 12'h132 || fill !== 2'd3) begin
      errors++; $display("FAIL rotate_down got %h f=%0d want 132 f=3", q_all, fill); end
    for (int i = 0; i < 3; i++) step(0, 2'b00, i[0], 4'h7, 12'heee);
  endtask

  task automatic test_depth2;
    logic [7:0] e;
    sb2.push_back(8'h01); mode2 = 2'b11; par2_in = 8'h01;
    @(posedge clk); #1 e = sb2.pop_front();
    checks++; if (q2 !== e) begin errors++; $display("FAIL d2_load got %h want %h", q2, e); end
    for (int i = 0; i < 9; i++) begin
      sb2.push_back(i < 4 ? (i[0] ? 8'h01 : 8'h10) : 8'h01);
      mode2 = i < 4 ? 2'b10 : 2'b00;
      @(posedge clk); #1 e = sb2.pop_front();
      checks++; if (q2 !== e) begin errors++; $display("FAIL d2_edge%0d got %h want %h", i, q2, e); end
    end
    checks++; if (fill2 !== 2'd2 || full2 !== 1'b1) begin
      errors++; $display("FAIL d2_fill got %0d/%b want 2/1", fill2, full2); end
  endtask

  task automatic test_parity;
    step(0, 2'b11, 0, 0, 12'h007);
    checks++; if (par !== exp_par(12'h007)) begin errors++; $display("FAIL par_007 got %b want %b", par, exp_par(12'h007)); end
    step(0, 2'b11, 0, 0, 12'h003);
    checks++; if (par !== 1'b0) begin errors++; $display("FAIL par_003 got %b want 0", par); end
  endtask

  initial begin
    #12;
    test_reset;
    test_shift_up;
    test_shift_down;
    test_rotate;
    test_depth2;
    test_parity;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_ring_reg.md
Name: shift_ring_reg

Overview:
- Parametrised register chain of DEPTH stages, each WIDTH bits wide, built on the team's flip-flop style: one rising-edge register per bit.
- Generalises the two-stage cross-coupled flip-flop swap into a multi-mode block:
  - hold
  - serial shift, both directions
  - ring rotate, both directions
  - parallel load
- Adds synchronous clear and a fill tracker.
- Used as delay line, serialiser/deserialiser and ring pattern generator in the exercise test benches.

Parameters:
- WIDTH, 4, bits per stage; legal range >=1.
- DEPTH, 4, number of stages; legal range >=2.
- FILL_W, $clog2(DEPTH+1), width of fill count; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- sclr  input  1  synchronous clear; highest priority after rst.
- mode  input  2  operation select: 00 hold, 01 shift, 10 rotate, 11 load.
- dir  input  1  0 = toward higher stage index, 1 = toward lower index.
- ser_in  input  WIDTH  serial data entering the chain in shift mode.
- par_in  input  WIDTH*DEPTH  parallel load data; stage i = par_in[i*WIDTH +: WIDTH].
- q_all  output  WIDTH*DEPTH  all stage contents; stage i = q_all[i*WIDTH +: WIDTH].
- ser_out  output  WIDTH  exit stage: stage DEPTH-1 when dir=0, stage 0 when dir=1.
- fill  output  FILL_W  number of valid stages, saturating at DEPTH.
- full  output  1  high when fill == DEPTH.
- par  output  1  parity; present only with the optional feature.

Behaviour:
- Reset (rst high, async, any time, including mid-operation): all stages 0, fill 0; so q_all=0, ser_out=0, full=0, par=0. Release is observed at the next rising clk.
- Priority per edge: rst > sclr > mode.
- sclr=1: same effect as reset, but synchronous, and it overrides any mode on that edge.
- mode 00 hold: all state unchanged.
- mode 01 shift, dir=0: stage0<=ser_in; stage i<=stage i-1 for i=1..DEPTH-1; old stage DEPTH-1 is discarded.
- mode 01 shift, dir=1: stage DEPTH-1<=ser_in; stage i<=stage i+1; old stage 0 is discarded.
- mode 01 fill: fill<=min(fill+1, DEPTH); it saturates and never wraps.
- mode 10 rotate, dir=0: stage0<=stage DEPTH-1; stage i<=stage i-1.
- mode 10 rotate, dir=1: stage DEPTH-1<=stage 0; stage i<=stage i+1.
- mode 10 fill: unchanged; no data lost. DEPTH=2 rotate is exactly the two-flop swap.
- mode 11 load: stage i<=par_in slice i; fill<=DEPTH.
- Latency: every update is visible on q_all one cycle after the sampling edge.
- ser_out, full and par are combinational decodes of registered state; no extra latency.
- dir change takes effect on the same edge it is sampled. ser_out selection follows dir combinationally.
- ser_out width equals stage width; no arithmetic beyond the fill increment.
- All inputs are sampled only at the rising clk edge; there are no latched paths.

Optional Feature:
- Macro: SHIFT_RING_PARITY_EN.
- Defined: par = XOR reduction of all WIDTH*DEPTH bits of q_all, updated combinationally from the stage registers.
- Not defined: no parity logic is generated; par is driven constant 0.
- Port list is identical in both builds.

Test Plan (WIDTH=4, DEPTH=3 unless noted):
- Reset and clear: rst pulse mid-shift -> q_all=0, fill=0, full=0 immediately, without waiting for an edge. Then load 0x321 followed by sclr=1 with mode=11 on the same edge -> q_all=0, fill=0.
- Shift dir=0: ser_in=1,2,3,4 on consecutive edges -> fill 1,2,3,3; full rises after the 3rd edge; final q_all=0x234; ser_out sequence 0,0,1,2.
- Shift dir=1 after load par_in=0xABC: ser_in=5 -> q_all=0x5AB; ser_out changes from stage0=C to B.
- Rotate: load 0x321; rotate dir=0 x3 -> q_all 0x213, 0x132, 0x321. Then rotate dir=1 once -> 0x132. fill stays 3 throughout.
- DEPTH=2 rotate: load stage0=1, stage1=0; rotate 4 edges -> stage0 toggles 0,1,0,1, matching the cross-coupled pair. Hold mode for 5 edges -> no change.
- Parity (macro defined): load 0x007 -> par=1; load 0x003 -> par=0. Macro undefined -> par=0 for both loads.
